// File: rtl/pipeline_drain_buffer_pkg.sv
// Shared defaults and width helper for the pipeline drain buffer family.
package pipeline_drain_buffer_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_SIZE  = 8;
    localparam int unsigned DEF_DEPTH = 16;

    // Width of a counter that must hold 0..n inclusive (n a power of two or stage count).
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/pipeline_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty derived from the occupancy count.
module pipeline_fifo
    import pipeline_drain_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointers wrap naturally at DEPTH; the count alone tells full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only slots behind a valid count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/pipeline_drain_buffer.sv
// Tracks which register-pipeline stages hold real words, drives the pipeline enable,
// and drains valid tail words into an output FIFO presented on a valid/ready port.
module pipeline_drain_buffer
    import pipeline_drain_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SIZE  = DEF_SIZE,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     src_valid,
    output logic                     src_ready,
    output logic                     pipe_enable,
    input  logic [WIDTH-1:0]         pipe_dataout,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [cnt_w(DEPTH)-1:0]  fifo_count,
    output logic [cnt_w(SIZE)-1:0]   inflight,
    output logic                     idle
);

    localparam int unsigned ICW = cnt_w(SIZE);

    logic [SIZE-1:0] vbits_q, vbits_d;
    logic [ICW-1:0]  inflight_q, inflight_d;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;

    // Stall only when a valid tail word cannot be stored; bubbles at the tail never stall.
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid & out_ready;
    assign pipe_enable = !(vbits_q[SIZE-1] & fifo_full & !pop);
    assign src_ready   = pipe_enable;
    assign push        = pipe_enable & vbits_q[SIZE-1];

    always_comb begin
        vbits_d = vbits_q;
        if (pipe_enable) begin
            vbits_d = {vbits_q[SIZE-2:0], src_valid};
        end
        inflight_d = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            inflight_d = inflight_d + ICW'(vbits_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vbits_q    <= '0;
            inflight_q <= '0;
        end else begin
            vbits_q    <= vbits_d;
            inflight_q <= inflight_d;
        end
    end

    pipeline_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (pipe_dataout),
        .rdata (out_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign inflight = inflight_q;
    assign idle     = (fifo_count == '0) && (inflight_q == '0);

endmodule

// File: tb/tb_pipeline_drain_buffer.sv
// Bench for pipeline_drain_buffer with a behavioural register pipeline, a cycle model
// of tracker/FIFO occupancy, and an acceptance-order scoreboard.
module tb_pipeline_drain_buffer;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SIZE  = 8;
    localparam int unsigned DEPTH = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              src_valid;
    logic              src_ready;
    logic              pipe_enable;
    logic [WIDTH-1:0]  pipe_dataout;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_ready;
    logic [4:0]        fifo_count;
    logic [3:0]        inflight;
    logic              idle;
    logic [WIDTH-1:0]  din;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;
    bit mon_en   = 1'b0;

    logic [WIDTH-1:0] stage_q [SIZE];
    logic [WIDTH-1:0] exp_q [$];
    logic [SIZE-1:0]  mv;
    int               m_cnt;

    typedef struct {
        logic        sv;
        logic [15:0] d;
        int          e_inf;
        int          e_cnt;
        logic        e_ov;
    } vec_t;

    vec_t tbl [16];

    always #5 clk = ~clk;

    pipeline_drain_buffer #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .pipe_enable  (pipe_enable),
        .pipe_dataout (pipe_dataout),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .fifo_count   (fifo_count),
        .inflight     (inflight),
        .idle         (idle)
    );

    // Behavioural register pipeline: no reset, shifts on enable.
    always @(posedge clk) begin
        if (pipe_enable) begin
            stage_q[0] <= din;
            for (int i = 1; i < SIZE; i++) stage_q[i] <= stage_q[i-1];
        end
    end
    assign pipe_dataout = stage_q[SIZE-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int popcnt(input logic [SIZE-1:0] v);
        int n = 0;
        for (int i = 0; i < SIZE; i++) n += int'(v[i]);
        return n;
    endfunction

    // Cycle model and scoreboard, sampled mid-cycle when inputs are stable.
    always @(negedge clk) begin
        if (mon_en) begin
            logic pop_m, en_m;
            logic [WIDTH-1:0] e;
            pop_m = (m_cnt != 0) && out_ready;
            en_m  = !(mv[SIZE-1] && (m_cnt == DEPTH) && !pop_m);
            chk("pipe_enable", 32'(pipe_enable), 32'(en_m));
            chk("src_ready", 32'(src_ready), 32'(en_m));
            chk("out_valid", 32'(out_valid), 32'(m_cnt != 0));
            chk("fifo_count", 32'(fifo_count), 32'(m_cnt));
            chk("inflight", 32'(inflight), 32'(popcnt(mv)));
            chk("idle", 32'(idle), 32'((m_cnt == 0) && (popcnt(mv) == 0)));
            if (!reset) begin
                mv    = '0;
                m_cnt = 0;
                exp_q.delete();
            end else begin
                if (pop_m) begin
                    n_out++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL out_unexpected: got %0h expected no word", out_data);
                    end else begin
                        checks--;
                        e = exp_q.pop_front();
                        chk("out_data", 32'(out_data), 32'(e));
                    end
                    m_cnt--;
                end
                if (en_m && mv[SIZE-1]) m_cnt++;
                if (en_m) begin
                    if (src_valid) exp_q.push_back(din);
                    mv = {mv[SIZE-2:0], src_valid};
                end
            end
        end
    end

    task automatic do_reset();
        src_valid = 1'b0;
        reset     = 1'b0;
        @(posedge clk); #2;
        reset     = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    initial begin
        int acc_c, lat_c, n0, acc_n, max_cnt, max_inf;
        bit gap, acc, dead_seen, got;

        tbl[0]  = '{1'b1, 16'h000A, 0, 0, 1'b0};
        tbl[1]  = '{1'b0, 16'hEEEE, 1, 0, 1'b0};
        tbl[2]  = '{1'b0, 16'hEEEE, 1, 0, 1'b0};
        tbl[3]  = '{1'b1, 16'h000B, 1, 0, 1'b0};
        tbl[4]  = '{1'b0, 16'hEEEE, 2, 0, 1'b0};
        tbl[5]  = '{1'b1, 16'h000C, 2, 0, 1'b0};
        tbl[6]  = '{1'b0, 16'hEEEE, 3, 0, 1'b0};
        tbl[7]  = '{1'b0, 16'hEEEE, 3, 0, 1'b0};
        tbl[8]  = '{1'b0, 16'hEEEE, 3, 0, 1'b0};
        tbl[9]  = '{1'b0, 16'hEEEE, 2, 1, 1'b1};
        tbl[10] = '{1'b0, 16'hEEEE, 2, 1, 1'b1};
        tbl[11] = '{1'b0, 16'hEEEE, 2, 1, 1'b1};
        tbl[12] = '{1'b0, 16'hEEEE, 1, 2, 1'b1};
        tbl[13] = '{1'b0, 16'hEEEE, 1, 2, 1'b1};
        tbl[14] = '{1'b0, 16'hEEEE, 0, 3, 1'b1};
        tbl[15] = '{1'b0, 16'hEEEE, 0, 3, 1'b1};

        mv = '0;
        m_cnt = 0;
        reset = 1'b0;
        src_valid = 1'b0;
        out_ready = 1'b0;
        din = 16'h0;
        tick();
        mon_en = 1'b1;
        tick();
        reset = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_pipe_enable", 32'(pipe_enable), 32'd1);

        // Streaming 1..32 with consumer always ready
        tick();
        out_ready = 1'b1; src_valid = 1'b1; din = 16'h0001;
        acc_c = -1; lat_c = -1; gap = 1'b0; n0 = n_out;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (src_valid && src_ready && acc_c < 0) acc_c = c;
            if (out_valid && lat_c < 0) lat_c = c;
            if (lat_c >= 0 && !out_valid && (n_out - n0) < 32) gap = 1'b1;
            acc = src_valid && src_ready;
            tick();
            if (acc) begin
                if (din == 16'd32) src_valid = 1'b0;
                else din = din + 16'd1;
            end
            if (idle && (n_out - n0) == 32) break;
        end
        chk("stream_latency", 32'(lat_c - acc_c - 1), 32'(SIZE));
        chk("stream_gap", 32'(gap), 32'd0);
        chk("stream_words", 32'(n_out - n0), 32'd32);
        chk("stream_idle", 32'(idle), 32'd1);

        // Backpressure fill: 30 words offered, consumer stalled
        do_reset();
        out_ready = 1'b0; src_valid = 1'b1; din = 16'h0101;
        acc_n = 0; max_cnt = 0; max_inf = 0; n0 = n_out;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (int'(inflight) > max_inf) max_inf = int'(inflight);
            acc = src_valid && src_ready;
            tick();
            if (acc) begin
                acc_n++;
                if (acc_n == 30) src_valid = 1'b0;
                else din = din + 16'd1;
            end
        end
        @(negedge clk);
        chk("bp_accepted", 32'(acc_n), 32'd24);
        chk("bp_max_count", 32'(max_cnt), 32'(DEPTH));
        chk("bp_max_inflight", 32'(max_inf), 32'(SIZE));
        chk("bp_stalled", 32'(pipe_enable), 32'd0);

        // Full FIFO, valid tail, consumer returns: push and pop together
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("full_pp_enable", 32'(pipe_enable), 32'd1);
                chk("full_pp_count0", 32'(fifo_count), 32'(DEPTH));
            end
            if (c == 1) chk("full_pp_count1", 32'(fifo_count), 32'(DEPTH));
            acc = src_valid && src_ready;
            tick();
            if (acc) begin
                acc_n++;
                if (acc_n == 30) src_valid = 1'b0;
                else din = din + 16'd1;
            end
            if (idle && !src_valid) break;
        end
        chk("bp_total_out", 32'(n_out - n0), 32'd30);
        chk("bp_idle", 32'(idle), 32'd1);

        // Bubble pattern, table-driven, consumer stalled
        do_reset();
        out_ready = 1'b0; n0 = n_out;
        for (int k = 0; k < 16; k++) begin
            src_valid = tbl[k].sv;
            din = tbl[k].d;
            @(negedge clk);
            chk($sformatf("bub_inflight[%0d]", k), 32'(inflight), 32'(tbl[k].e_inf));
            chk($sformatf("bub_count[%0d]", k), 32'(fifo_count), 32'(tbl[k].e_cnt));
            chk($sformatf("bub_out_valid[%0d]", k), 32'(out_valid), 32'(tbl[k].e_ov));
            tick();
        end
        src_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !idle; c++) tick();
        chk("bub_words", 32'(n_out - n0), 32'd3);

        // Stale pipeline contents must not survive reset
        do_reset();
        out_ready = 1'b0; src_valid = 1'b1; din = 16'hDEAD;
        for (int c = 0; c < 10; c++) tick();
        do_reset();
        @(negedge clk);
        chk("stale_count", 32'(fifo_count), 32'd0);
        chk("stale_out_valid", 32'(out_valid), 32'd0);
        tick();
        out_ready = 1'b1; dead_seen = 1'b0; n0 = n_out;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) dead_seen = 1'b1;
            tick();
        end
        chk("stale_no_output", 32'(dead_seen), 32'd0);
        din = 16'h1234; src_valid = 1'b1;
        tick();
        src_valid = 1'b0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                chk("stale_first_word", 32'(out_data), 32'h1234);
            end
            tick();
        end
        chk("stale_first_seen", 32'(got), 32'd1);

        // Mid-operation reset with 5 buffered and 3 in flight
        do_reset();
        out_ready = 1'b0; din = 16'h0201;
        for (int c = 0; c < 13; c++) begin
            src_valid = (c < 8);
            tick();
            din = din + 16'd1;
        end
        src_valid = 1'b0;
        @(negedge clk);
        chk("mid_count", 32'(fifo_count), 32'd5);
        chk("mid_inflight", 32'(inflight), 32'd3);
        tick();
        do_reset();
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_inflight", 32'(inflight), 32'd0);
        chk("mid_rst_enable", 32'(pipe_enable), 32'd1);
        tick();
        din = 16'h7777; src_valid = 1'b1; out_ready = 1'b1;
        tick();
        src_valid = 1'b0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                chk("mid_first_word", 32'(out_data), 32'h7777);
            end
            tick();
        end
        chk("mid_first_seen", 32'(got), 32'd1);
        for (int c = 0; c < 10; c++) tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
